// File: rtl/lte_hw_acc_scr_ctrl_if.sv
// Stream bundle between encoder, scrambler controller and scrambler.
// master drives data/valid/sof/lof and samples ready; slave does the reverse.
interface lte_hw_acc_scr_ctrl_if #(
  parameter int DATA_WIDTH = 1
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  sof;
  logic [7:0]            lof;
  logic                  ready;

  modport master (
    output data, valid, sof, lof,
    input  ready
  );

  modport slave (
    input  data, valid, sof, lof,
    output ready
  );
endinterface

// File: rtl/lte_hw_acc_scr_ctrl.sv
// Scrambler sequencing: seeds the 20-entry x1/x2 map, tracks subframes,
// gates the stream while writing. Ports: up (slave), scr (master), cfg_*, sfn_*.
module lte_hw_acc_scr_ctrl #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  lte_hw_acc_scr_ctrl_if.slave  up,
  lte_hw_acc_scr_ctrl_if.master scr,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_rnti,
  input  logic [8:0]            cfg_cell_id,
  input  logic                  cfg_q,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [4:0]            scr_cfg_addr,
  output logic [30:0]           scr_cfg_data,
  output logic                  scr_cfg_wr,
  input  logic                  sfn_load,
  input  logic [3:0]            sfn_load_val,
  output logic [3:0]            sfn,
  output logic                  err_lof
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [30:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rnti_q, rnti_d;
  logic [8:0]  cell_q, cell_d;
  logic        qb_q, qb_d;
  logic [7:0]  rem_q, rem_d;
  logic        in_frame_q, in_frame_d;
  logic [3:0]  sfn_q, sfn_d;
  logic        err_q, err_d;

  logic                  gate;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] pass_data;

  function automatic logic [30:0] seed(
    input logic [4:0]  i,
    input logic [15:0] r,
    input logic        q,
    input logic [8:0]  c
  );
    if (!i[0]) return 31'd1;
    return {1'b0, r, 14'd0} + {17'd0, q, 13'd0}
         + {18'd0, i[4:1], 9'd0} + {22'd0, c};
  endfunction

  // rstn term keeps the stream transparent while in reset
  assign gate = rstn & ((state_q == S_WRITE) |
                        (state_q == S_DONE));

  assign pass_data = up.data;
  assign scr.data  = pass_data;
  assign scr.sof   = up.sof;
  assign scr.lof   = up.lof;
  assign scr.valid = up.valid & ~gate;
  assign up.ready  = scr.ready & ~gate;
  assign xfer      = scr.valid & scr.ready;

  always_comb begin
    rem_d      = rem_q;
    in_frame_d = in_frame_q;
    sfn_d      = sfn_q;
    err_d      = err_q;
    if (xfer & up.sof) begin
      rem_d      = up.lof - 8'd1;
      in_frame_d = (up.lof >= 8'd2);
      err_d      = err_q | (up.lof < 8'd2);
    end else if (xfer & in_frame_q) begin
      rem_d = rem_q - 8'd1;
      if (rem_q == 8'd1) in_frame_d = 1'b0;
    end
    if (sfn_load) begin
      sfn_d = (sfn_load_val > 4'd9) ? 4'd0 : sfn_load_val;
    end else if (xfer & up.sof) begin
      sfn_d = (sfn_q == 4'd9) ? 4'd0 : sfn_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    rnti_d  = rnti_q;
    cell_d  = cell_q;
    qb_d    = qb_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          rnti_d = cfg_rnti;
          cell_d = cfg_cell_id;
          qb_d   = cfg_q;
          idx_d  = 5'd0;
          if (in_frame_d) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            data_d  = 31'd1;
          end
        end
      end
      S_WAIT: begin
        if (!in_frame_d) begin
          state_d = S_WRITE;
          wr_d    = 1'b1;
          idx_d   = 5'd0;
          data_d  = 31'd1;
        end
      end
      S_WRITE: begin
        if (idx_q == 5'd19) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + 5'd1;
          wr_d   = 1'b1;
          data_d = seed(idx_d, rnti_q, qb_q, cell_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= 5'd0;
      data_q     <= 31'd0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rnti_q     <= 16'd0;
      cell_q     <= 9'd0;
      qb_q       <= 1'b0;
      rem_q      <= 8'd0;
      in_frame_q <= 1'b0;
      sfn_q      <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rnti_q     <= rnti_d;
      cell_q     <= cell_d;
      qb_q       <= qb_d;
      rem_q      <= rem_d;
      in_frame_q <= in_frame_d;
      sfn_q      <= sfn_d;
      err_q      <= err_d;
    end
  end

  assign scr_cfg_addr = idx_q;
  assign scr_cfg_data = data_q;
  assign scr_cfg_wr   = wr_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign sfn          = sfn_q;
  assign err_lof      = err_q;

endmodule

// File: tb/tb_lte_hw_acc_scr_ctrl.sv
// Directed bench for lte_hw_acc_scr_ctrl: reprogram, deferral, gating,
// subframe wrap, error/ignore and reset abort.
module tb_lte_hw_acc_scr_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start;
  logic [15:0] cfg_rnti;
  logic [8:0]  cfg_cell_id;
  logic        cfg_q;
  logic        cfg_busy, cfg_done;
  logic [4:0]  scr_cfg_addr;
  logic [30:0] scr_cfg_data;
  logic        scr_cfg_wr;
  logic        sfn_load;
  logic [3:0]  sfn_load_val;
  logic [3:0]  sfn;
  logic        err_lof;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int base;
  bit ok;

  int sfn_tab[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

  lte_hw_acc_scr_ctrl_if #(.DATA_WIDTH(1)) up_if ();
  lte_hw_acc_scr_ctrl_if #(.DATA_WIDTH(1)) scr_if ();

  lte_hw_acc_scr_ctrl #(.DATA_WIDTH(1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .up           (up_if),
    .scr          (scr_if),
    .cfg_start    (cfg_start),
    .cfg_rnti     (cfg_rnti),
    .cfg_cell_id  (cfg_cell_id),
    .cfg_q        (cfg_q),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .scr_cfg_addr (scr_cfg_addr),
    .scr_cfg_data (scr_cfg_data),
    .scr_cfg_wr   (scr_cfg_wr),
    .sfn_load     (sfn_load),
    .sfn_load_val (sfn_load_val),
    .sfn          (sfn),
    .err_lof      (err_lof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scr_cfg_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic s,
                      input logic [7:0] l,
                      input logic cs);
    up_if.valid = 1'b1;
    up_if.sof   = s;
    up_if.lof   = l;
    cfg_start   = cs;
    #1;
    chk("beat_ready", {31'd0, up_if.ready}, 32'd1);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    cfg_start     = 1'b0;
    cfg_rnti      = 16'd0;
    cfg_cell_id   = 9'd0;
    cfg_q         = 1'b0;
    sfn_load      = 1'b0;
    sfn_load_val  = 4'd0;
    up_if.data    = 1'b1;
    up_if.valid   = 1'b1;
    up_if.sof     = 1'b1;
    up_if.lof     = 8'd5;
    scr_if.ready  = 1'b1;
    #1;
    chk("rst_up_ready", {31'd0, up_if.ready}, 32'd1);
    chk("rst_scr_valid", {31'd0, scr_if.valid}, 32'd1);
    chk("pass_data", {31'd0, scr_if.data}, 32'd1);
    chk("pass_sof", {31'd0, scr_if.sof}, 32'd1);
    chk("pass_lof", {24'd0, scr_if.lof}, 32'd5);
    scr_if.ready = 1'b0;
    #1;
    chk("rst_up_ready0", {31'd0, up_if.ready}, 32'd0);
    scr_if.ready = 1'b1;
    tick();
    tick();
    chk("rst_sfn", {28'd0, sfn}, 32'd0);
    chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_wr", {31'd0, scr_cfg_wr}, 32'd0);
    chk("rst_addr", {27'd0, scr_cfg_addr}, 32'd0);
    chk("rst_data", {1'b0, scr_cfg_data}, 32'd0);
    chk("rst_err", {31'd0, err_lof}, 32'd0);
    up_if.valid = 1'b0;
    up_if.sof   = 1'b0;
    rstn        = 1'b1;
    tick();

    // idle reprogram
    cfg_rnti    = 16'h1234;
    cfg_cell_id = 9'd503;
    cfg_q       = 1'b1;
    cfg_start   = 1'b1;
    base        = wr_cnt;
    #1;
    chk("c0_ready", {31'd0, up_if.ready}, 32'd1);
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("w_wr", {31'd0, scr_cfg_wr}, 32'd1);
      chk("w_addr", {27'd0, scr_cfg_addr}, i);
      chk("w_gate", {31'd0, up_if.ready}, 32'd0);
      if (i == 0) chk("d0", {1'b0, scr_cfg_data}, 32'd1);
      if (i == 1) chk("d1", {1'b0, scr_cfg_data}, 32'h048D21F7);
      if (i == 6) chk("d6", {1'b0, scr_cfg_data}, 32'd1);
      if (i == 7) chk("d7", {1'b0, scr_cfg_data}, 32'h048D27F7);
      if (i == 19) chk("d19", {1'b0, scr_cfg_data}, 32'h048D33F7);
      tick();
    end
    chk("c21_wr", {31'd0, scr_cfg_wr}, 32'd0);
    chk("c21_done", {31'd0, cfg_done}, 32'd1);
    chk("c21_busy", {31'd0, cfg_busy}, 32'd1);
    chk("c21_gate", {31'd0, up_if.ready}, 32'd0);
    tick();
    chk("c22_done", {31'd0, cfg_done}, 32'd0);
    chk("c22_busy", {31'd0, cfg_busy}, 32'd0);
    chk("c22_ready", {31'd0, up_if.ready}, 32'd1);
    chk("idle_cnt", wr_cnt - base, 32'd20);

    // deferred write
    base = wr_cnt;
    beat(1'b1, 8'd10, 1'b0);
    beat(1'b0, 8'd10, 1'b0);
    beat(1'b0, 8'd10, 1'b1);
    for (int b = 4; b <= 10; b++) begin
      chk("def_busy", {31'd0, cfg_busy}, 32'd1);
      chk("def_nowr", {31'd0, scr_cfg_wr}, 32'd0);
      beat(1'b0, 8'd10, 1'b0);
    end
    up_if.valid = 1'b0;
    chk("def_wr1", {31'd0, scr_cfg_wr}, 32'd1);
    chk("def_addr0", {27'd0, scr_cfg_addr}, 32'd0);
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      if (!cfg_busy) ok = 1'b1;
    end
    chk("def_timeout", {31'd0, ok}, 32'd1);
    chk("def_cnt", wr_cnt - base, 32'd20);

    // boundary gating with new seeds
    cfg_rnti    = 16'h0001;
    cfg_cell_id = 9'd0;
    cfg_q       = 1'b0;
    beat(1'b1, 8'd3, 1'b0);
    beat(1'b0, 8'd3, 1'b1);
    beat(1'b0, 8'd3, 1'b0);
    up_if.sof = 1'b1;
    up_if.lof = 8'd4;
    for (int i = 0; i < 21; i++) begin
      #1;
      chk("bnd_ready", {31'd0, up_if.ready}, 32'd0);
      chk("bnd_valid", {31'd0, scr_if.valid}, 32'd0);
      tick();
    end
    chk("bnd_seed", {1'b0, scr_cfg_data}, 32'h00005200);
    beat(1'b1, 8'd4, 1'b0);
    for (int b = 0; b < 3; b++) beat(1'b0, 8'd4, 1'b0);
    up_if.valid = 1'b0;

    // subframe wrap from reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int f = 0; f < 11; f++) begin
      chk("sfn_sof", {28'd0, sfn}, sfn_tab[f]);
      beat(1'b1, 8'd4, 1'b0);
      for (int b = 0; b < 3; b++) begin
        chk("sfn_hold", {28'd0, sfn}, sfn_tab[f+1]);
        beat(1'b0, 8'd4, 1'b0);
      end
    end
    up_if.valid  = 1'b0;
    chk("sfn_after", {28'd0, sfn}, 32'd1);
    sfn_load     = 1'b1;
    sfn_load_val = 4'd12;
    tick();
    sfn_load = 1'b0;
    chk("sfn_ld12", {28'd0, sfn}, 32'd0);
    sfn_load     = 1'b1;
    sfn_load_val = 4'd7;
    beat(1'b1, 8'd2, 1'b0);
    sfn_load = 1'b0;
    chk("sfn_ld_sof", {28'd0, sfn}, 32'd7);
    beat(1'b0, 8'd2, 1'b0);
    up_if.valid = 1'b0;
    tick();
    tick();
    chk("sfn_stable", {28'd0, sfn}, 32'd7);

    // error and ignore
    chk("err_clr", {31'd0, err_lof}, 32'd0);
    base = wr_cnt;
    beat(1'b1, 8'd1, 1'b1);
    up_if.valid = 1'b0;
    chk("err_set", {31'd0, err_lof}, 32'd1);
    chk("err_nohold", {31'd0, scr_cfg_wr}, 32'd1);
    chk("err_addr0", {27'd0, scr_cfg_addr}, 32'd0);
    tick();
    tick();
    tick();
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      if (!cfg_busy) ok = 1'b1;
    end
    chk("ign_timeout", {31'd0, ok}, 32'd1);
    chk("ign_cnt", wr_cnt - base, 32'd20);
    tick();
    tick();
    tick();
    chk("ign_idle", {31'd0, cfg_busy}, 32'd0);
    chk("ign_cnt2", wr_cnt - base, 32'd20);
    chk("err_sticky", {31'd0, err_lof}, 32'd1);
    chk("sfn_pre_abort", {28'd0, sfn}, 32'd8);

    // reset abort
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("ab_wr", {31'd0, scr_cfg_wr}, 32'd1);
    chk("ab_addr", {27'd0, scr_cfg_addr}, 32'd7);
    rstn = 1'b0;
    #1;
    chk("ab_rst_ready", {31'd0, up_if.ready}, 32'd1);
    tick();
    chk("ab_nowr", {31'd0, scr_cfg_wr}, 32'd0);
    chk("ab_busy", {31'd0, cfg_busy}, 32'd0);
    chk("ab_sfn", {28'd0, sfn}, 32'd0);
    chk("ab_err", {31'd0, err_lof}, 32'd0);
    rstn = 1'b1;
    tick();
    tick();
    chk("ab_idle", {31'd0, cfg_busy}, 32'd0);
    chk("ab_idle_wr", {31'd0, scr_cfg_wr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
